// File: rtl/frame_buffer_arbiter_if.sv
// ---------------------------------------------------------------------------
// frame_buffer_arbiter_if
//
// Purpose: bundles every non-clock signal of the frame buffer arbiter. This
// covers the scanout read port, the pixel-writer handshake, the frame/vblank
// controls, the single RAM port and the status outputs.
//
// Modports:
//   slave  - the arbiter's own view (consumes requests, drives RAM + status)
//   master - the environment's view (scanout, writer, RAM model, observers)
//
// Signals:
//   rd_req, rd_addr[15:0]          scanout read request / pixel number
//   rd_data[5:0], rd_valid         read colour, valid one cycle after rd_req
//   wr_valid, wr_ready             writer handshake
//   wr_addr[15:0], wr_color[5:0]   write pixel number and colour
//   frame_done, vblank             frame complete pulse, vertical blank level
//   mem_addr[16:0], mem_we         RAM address {bank, pixel} and write strobe
//   mem_wdata[5:0], mem_rdata[5:0] RAM write / read data
//   front_bank, swap_pending       bank status
//   fifo_level[LVL_W-1:0]          write FIFO occupancy
//   stall_count[15:0]              blocked-writer cycle count (may be tied 0)
// ---------------------------------------------------------------------------
interface frame_buffer_arbiter_if #(
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
);
  logic             rd_req;
  logic [15:0]      rd_addr;
  logic [5:0]       rd_data;
  logic             rd_valid;
  logic             wr_valid;
  logic             wr_ready;
  logic [15:0]      wr_addr;
  logic [5:0]       wr_color;
  logic             frame_done;
  logic             vblank;
  logic [16:0]      mem_addr;
  logic             mem_we;
  logic [5:0]       mem_wdata;
  logic [5:0]       mem_rdata;
  logic             front_bank;
  logic             swap_pending;
  logic [LVL_W-1:0] fifo_level;
  logic [15:0]      stall_count;

  modport slave (
    input  rd_req, rd_addr, wr_valid, wr_addr, wr_color, frame_done, vblank,
           mem_rdata,
    output rd_data, rd_valid, wr_ready, mem_addr, mem_we, mem_wdata,
           front_bank, swap_pending, fifo_level, stall_count
  );

  modport master (
    output rd_req, rd_addr, wr_valid, wr_addr, wr_color, frame_done, vblank,
           mem_rdata,
    input  rd_data, rd_valid, wr_ready, mem_addr, mem_we, mem_wdata,
           front_bank, swap_pending, fifo_level, stall_count
  );
endinterface

// File: rtl/frame_buffer_arbiter.sv
// ---------------------------------------------------------------------------
// frame_buffer_arbiter
//
// Purpose: owns the single-port, double-banked frame buffer RAM. VGA scanout
// reads always win the port and have a fixed one-cycle latency. Pixel-writer
// stores are queued in a small FIFO and drained into the back bank on cycles
// with no read. Front and back banks are swapped during vblank once the
// writer reports frame completion and the FIFO has drained, so the display
// never tears.
//
// Ports:
//   vga_clk  - 25 MHz pixel clock, all logic on this clock
//   reset_n  - asynchronous active-low reset
//   bus      - frame_buffer_arbiter_if.slave (read, write, RAM, status)
//
// Optional feature:
//   FBA_STALL_CNT_EN - when defined, stall_count counts cycles in which the
//   writer is blocked (saturating, cleared on each swap). When undefined,
//   stall_count is tied to zero and no counter is built.
// ---------------------------------------------------------------------------
module frame_buffer_arbiter #(
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input logic                   vga_clk,
  input logic                   reset_n,
  frame_buffer_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic {
    RUN,
    WAIT_SWAP
  } state_t;

  state_t           state_q;
  logic             frontBank_q;
  logic             swapPending_q;
  logic             rdValid_q;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [15:0]      fifoAddr_q  [FIFO_DEPTH];
  logic [5:0]       fifoColor_q [FIFO_DEPTH];

  logic fifoEmpty;
  logic fifoFull;
  logic wrReady;
  logic push;
  logic pop;
  logic swapFire;

  // FIFO control. wr_ready depends only on registered state, so a pop in a
  // full cycle cannot open the door in that same cycle. Writes are refused
  // while a swap is pending so the FIFO can drain before the swap.
  always_comb begin
    fifoEmpty = (level_q == '0);
    fifoFull  = (level_q == LVL_W'(FIFO_DEPTH));
    wrReady   = !fifoFull && !swapPending_q;
    push      = bus.wr_valid && wrReady;
    pop       = !bus.rd_req && !fifoEmpty;
    swapFire  = (state_q == WAIT_SWAP) && bus.vblank && fifoEmpty && !bus.rd_req;
    wrPtr_d   = push ? wrPtr_q + PTR_W'(1) : wrPtr_q;
    rdPtr_d   = pop  ? rdPtr_q + PTR_W'(1) : rdPtr_q;
    level_d   = level_q + LVL_W'(push) - LVL_W'(pop);
  end

  // RAM port schedule: reads first, then FIFO drain into the back bank,
  // otherwise an idle read of the front bank.
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    bus.mem_addr  = {frontBank_q, 16'd0};
    if (bus.rd_req) begin
      bus.mem_addr = {frontBank_q, bus.rd_addr};
    end else if (!fifoEmpty) begin
      bus.mem_we    = 1'b1;
      bus.mem_addr  = {~frontBank_q, fifoAddr_q[rdPtr_q]};
      bus.mem_wdata = fifoColor_q[rdPtr_q];
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
    end
  end

  // FIFO storage needs no reset; only entries below the level are ever read
  always_ff @(posedge vga_clk) begin
    if (push) begin
      fifoAddr_q[wrPtr_q]  <= bus.wr_addr;
      fifoColor_q[wrPtr_q] <= bus.wr_color;
    end
  end

  // Read valid is rd_req delayed by the RAM's one-cycle latency
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rdValid_q <= 1'b0;
    end else begin
      rdValid_q <= bus.rd_req;
    end
  end

  // Bank swap FSM. frame_done is only honoured in RUN; the swap waits for a
  // cycle that is in vblank, has an empty FIFO and no read on the port.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RUN;
      frontBank_q   <= 1'b0;
      swapPending_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.frame_done) begin
            state_q       <= WAIT_SWAP;
            swapPending_q <= 1'b1;
          end
        end
        WAIT_SWAP: begin
          if (swapFire) begin
            state_q       <= RUN;
            swapPending_q <= 1'b0;
            frontBank_q   <= ~frontBank_q;
          end
        end
        default: begin
          state_q       <= RUN;
          swapPending_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef FBA_STALL_CNT_EN
  logic [15:0] stallCount_q;

  // Saturating count of blocked-writer cycles, restarted at each swap
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      stallCount_q <= 16'd0;
    end else if (swapFire) begin
      stallCount_q <= 16'd0;
    end else if (bus.wr_valid && !wrReady && (stallCount_q != 16'hFFFF)) begin
      stallCount_q <= stallCount_q + 16'd1;
    end
  end

  assign bus.stall_count = stallCount_q;
`else
  assign bus.stall_count = 16'd0;
`endif

  assign bus.rd_data      = bus.mem_rdata;
  assign bus.rd_valid     = rdValid_q;
  assign bus.wr_ready     = wrReady;
  assign bus.front_bank   = frontBank_q;
  assign bus.swap_pending = swapPending_q;
  assign bus.fifo_level   = level_q;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// ---------------------------------------------------------------------------
// tb_frame_buffer_arbiter
//
// Scoreboard bench for frame_buffer_arbiter. Stimulus pushes expected RAM
// writes and expected read colours into queues; a monitor on the falling
// edge pops and compares whenever the DUT strobes mem_we or rd_valid. A
// small RAM model returns a colour derived from the registered address.
// ---------------------------------------------------------------------------
module tb_frame_buffer_arbiter;

  logic vga_clk;
  logic reset_n;

  frame_buffer_arbiter_if #(.FIFO_DEPTH(8)) bus ();

  frame_buffer_arbiter #(.FIFO_DEPTH(8)) dut (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  logic [22:0] writeQ [$];
  logic [5:0]  readQ  [$];
  logic        expFront;

  // 25 MHz clock
  initial vga_clk = 1'b0;
  always #20 vga_clk = ~vga_clk;

  // RAM model colour for a given {bank, pixel}
  function automatic logic [5:0] ramModel(input logic [16:0] a);
    return a[5:0] ^ a[11:6] ^ {a[16], a[15:12], 1'b1};
  endfunction

  // RAM model: read data appears one cycle after the address
  always @(posedge vga_clk) begin
    bus.mem_rdata <= ramModel(bus.mem_addr);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: compare completed reads and RAM writes against the queues,
  // then record the expectation for any read issued this cycle.
  always @(negedge vga_clk) begin
    if (reset_n) begin
      if (bus.rd_valid) begin
        if (readQ.size() == 0) begin
          checkOutput("unexpected rd_valid", 32'(bus.rd_valid), 32'd0);
        end else begin
          checkOutput("rd_data", 32'(bus.rd_data), 32'(readQ.pop_front()));
        end
      end
      if (bus.mem_we) begin
        if (writeQ.size() == 0) begin
          checkOutput("unexpected mem_we", 32'(bus.mem_we), 32'd0);
        end else begin
          checkOutput("mem write {addr,data}", 32'({bus.mem_addr, bus.mem_wdata}),
                      32'(writeQ.pop_front()));
        end
      end
      if (bus.rd_req) begin
        checkOutput("read addr", 32'(bus.mem_addr), 32'({expFront, bus.rd_addr}));
        readQ.push_back(ramModel({expFront, bus.rd_addr}));
      end
    end
  end

  // Advance to just after the next rising edge
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge vga_clk);
      #1;
    end
  endtask

  // Offer one pixel and wait (bounded) until it is accepted; wr_valid stays
  // high so back-to-back calls give back-to-back pushes.
  task automatic pushPixel(input logic [15:0] addr, input logic [5:0] color);
    bit accepted = 0;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = addr;
    bus.wr_color = color;
    for (int i = 0; i < 50 && !accepted; i++) begin
      if (bus.wr_ready) begin
        writeQ.push_back({~expFront, addr, color});
        accepted = 1;
      end
      tick();
    end
    if (!accepted) checkOutput("push timeout", 32'd0, 32'd1);
  endtask

  task automatic applyStimulus();
    // Reset and idle
    reset_n        = 1'b0;
    expFront       = 1'b0;
    bus.rd_req     = 1'b0;
    bus.rd_addr    = 16'd0;
    bus.wr_valid   = 1'b0;
    bus.wr_addr    = 16'd0;
    bus.wr_color   = 6'd0;
    bus.frame_done = 1'b0;
    bus.vblank     = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick();
    checkOutput("reset front_bank", 32'(bus.front_bank), 32'd0);
    checkOutput("reset wr_ready", 32'(bus.wr_ready), 32'd1);
    checkOutput("reset fifo_level", 32'(bus.fifo_level), 32'd0);
    checkOutput("reset swap_pending", 32'(bus.swap_pending), 32'd0);
    checkOutput("reset rd_valid", 32'(bus.rd_valid), 32'd0);
    checkOutput("reset mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("reset stall_count", 32'(bus.stall_count), 32'd0);

    // Single read of pixel 0x1234 from bank 0
    bus.rd_req  = 1'b1;
    bus.rd_addr = 16'h1234;
    #1;
    checkOutput("read mem_addr", 32'(bus.mem_addr), 32'h01234);
    checkOutput("read mem_we", 32'(bus.mem_we), 32'd0);
    tick();
    bus.rd_req = 1'b0;
    checkOutput("rd_valid latency", 32'(bus.rd_valid), 32'd1);
    tick(2);

    // Write drain into back bank 1
    pushPixel(16'd5, 6'h11);
    pushPixel(16'd6, 6'h22);
    pushPixel(16'd7, 6'h33);
    bus.wr_valid = 1'b0;
    tick(2);
    checkOutput("drain fifo_level", 32'(bus.fifo_level), 32'd0);
    checkOutput("drain queue empty", 32'(writeQ.size()), 32'd0);

    // Read priority: fill the FIFO while reads own the port
    bus.rd_req  = 1'b1;
    bus.rd_addr = 16'h0400;
    for (int i = 0; i < 8; i++) begin
      pushPixel(16'h0100 + 16'(i), 6'(i + 8));
    end
    bus.wr_valid = 1'b0;
    tick(12);
    checkOutput("full fifo_level", 32'(bus.fifo_level), 32'd8);
    checkOutput("full wr_ready", 32'(bus.wr_ready), 32'd0);
    checkOutput("full writes held", 32'(writeQ.size()), 32'd8);
    bus.rd_req = 1'b0;
    #1;
    checkOutput("full pop keeps wr_ready low", 32'(bus.wr_ready), 32'd0);
    tick(8);
    checkOutput("burst fifo_level", 32'(bus.fifo_level), 32'd0);
    checkOutput("burst wr_ready", 32'(bus.wr_ready), 32'd1);
    checkOutput("burst queue empty", 32'(writeQ.size()), 32'd0);

    // Swap with empty FIFO; writer blocked for 10 cycles meanwhile
    bus.frame_done = 1'b1;
    tick();
    bus.frame_done = 1'b0;
    checkOutput("swap_pending set", 32'(bus.swap_pending), 32'd1);
    checkOutput("wr_ready blocked", 32'(bus.wr_ready), 32'd0);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 16'h0BAD;
    tick(10);
    bus.wr_valid = 1'b0;
`ifdef FBA_STALL_CNT_EN
    checkOutput("stall_count blocked", 32'(bus.stall_count), 32'd10);
`else
    checkOutput("stall_count tied", 32'(bus.stall_count), 32'd0);
`endif
    checkOutput("no swap outside vblank", 32'(bus.front_bank), 32'd0);
    bus.vblank = 1'b1;
    tick();
    expFront   = 1'b1;
    bus.vblank = 1'b0;
    checkOutput("swap front_bank", 32'(bus.front_bank), 32'd1);
    checkOutput("swap_pending clear", 32'(bus.swap_pending), 32'd0);
    checkOutput("stall_count after swap", 32'(bus.stall_count), 32'd0);
    pushPixel(16'h000A, 6'h2A);
    bus.wr_valid = 1'b0;
    tick(2);
    bus.rd_req  = 1'b1;
    bus.rd_addr = 16'h0042;
    tick();
    bus.rd_req = 1'b0;
    tick(2);

    // Deferred swap: entries queued, reads hold the port through a vblank
    bus.rd_req  = 1'b1;
    bus.rd_addr = 16'h0100;
    for (int i = 0; i < 4; i++) begin
      pushPixel(16'h0020 + 16'(i), 6'(i + 1));
    end
    bus.wr_valid   = 1'b0;
    bus.vblank     = 1'b1;
    bus.frame_done = 1'b1;
    tick();
    bus.frame_done = 1'b0;
    tick(3);
    checkOutput("deferred pending", 32'(bus.swap_pending), 32'd1);
    checkOutput("deferred front", 32'(bus.front_bank), 32'd1);
    checkOutput("deferred level", 32'(bus.fifo_level), 32'd4);
    bus.frame_done = 1'b1;
    tick();
    bus.frame_done = 1'b0;
    bus.vblank     = 1'b0;
    tick(3);
    checkOutput("no swap after vblank falls", 32'(bus.front_bank), 32'd1);
    checkOutput("still pending", 32'(bus.swap_pending), 32'd1);
    bus.vblank = 1'b1;
    bus.rd_req = 1'b0;
    tick(4);
    checkOutput("deferred drained", 32'(bus.fifo_level), 32'd0);
    checkOutput("no swap while draining", 32'(bus.front_bank), 32'd1);
    bus.frame_done = 1'b1;
    tick();
    bus.frame_done = 1'b0;
    expFront       = 1'b0;
    checkOutput("deferred swap front", 32'(bus.front_bank), 32'd0);
    checkOutput("deferred swap clear", 32'(bus.swap_pending), 32'd0);
    tick();
    checkOutput("swap-cycle frame_done ignored", 32'(bus.swap_pending), 32'd0);
    bus.vblank = 1'b0;
    tick(3);
    checkOutput("write queue empty", 32'(writeQ.size()), 32'd0);
    checkOutput("read queue empty", 32'(readQ.size()), 32'd0);
  endtask

  // Hard time limit so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    applyStimulus();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
